// File: rtl/toggle_pulse_decoder.sv
// Toggle-line receiver: synchronises each TIN bit, turns every level change into a one-cycle PULSE and counts it.
// Latency: TIN change to PULSE/count = SYNC_STAGES+1 edges; RD_REQ to RD_ACK/RD_DATA = 1 edge.
// Backpressure: none; reads are accepted every cycle, and toggles closer than 2 cycles apart are outside the link contract.
module toggle_pulse_decoder #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [NCH-1:0]   TIN,
  output logic             READY,
  output logic [NCH-1:0]   PULSE,
  output logic [NCH-1:0]   OVF,
  input  logic             RD_REQ,
  input  logic [3:0]       RD_CH,
  output logic             RD_ACK,
  output logic [CNT_W-1:0] RD_DATA
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [2:0]       prime_cnt;
  logic             run;
  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   sync_lvl;
  logic [NCH-1:0]   last_q;
  logic [NCH-1:0]   edge_det;
  logic [NCH-1:0]   rd_hit;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] rd_sel;

  assign run      = (state == ST_RUN);
  assign READY    = run;
  assign sync_lvl = sync_q[SYNC_STAGES-1];
  // Edges seen before RUN are swallowed so a line that is already high out of reset never counts.
  assign edge_det = (sync_lvl ^ last_q) & {NCH{run}};

  // Control FSM: PRIME holds for SYNC_STAGES+1 cycles so the synchroniser and last[] settle first.
  always_ff @(posedge CP) begin
    if (!CD) begin
      state     <= ST_RESET;
      prime_cnt <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state     <= ST_PRIME;
          prime_cnt <= '0;
        end
        ST_PRIME: begin
          if (prime_cnt == 3'(SYNC_STAGES)) begin
            state <= ST_RUN;
          end else begin
            prime_cnt <= prime_cnt + 3'd1;
          end
        end
        ST_RUN: state <= ST_RUN;
        default: state <= ST_RESET;
      endcase
    end
  end

  // Synchroniser chain per channel, stage 0 samples the asynchronous toggle lines.
  always_ff @(posedge CP) begin
    if (!CD) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= TIN;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Previous synchronised level; tracks in every state so PRIME absorbs the initial line level.
  always_ff @(posedge CP) begin
    if (!CD) begin
      last_q <= '0;
    end else begin
      last_q <= sync_lvl;
    end
  end

  // Registered event strobe, one cycle per detected level change.
  always_ff @(posedge CP) begin
    if (!CD) begin
      PULSE <= '0;
    end else begin
      PULSE <= edge_det;
    end
  end

  // Read decode: only legal channels in RUN hit a counter; everything else reads back zero.
  always_comb begin
    rd_hit = '0;
    rd_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_hit[i] = RD_REQ && run && (RD_CH == 4'(i));
      if (rd_hit[i]) begin
        rd_sel = cnt_q[i];
      end
    end
  end

  // Saturating per-channel counters; a clear that collides with an event keeps that event as count 1.
  always_ff @(posedge CP) begin
    if (!CD) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      OVF <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rd_hit[i]) begin
          cnt_q[i] <= edge_det[i] ? CNT_ONE : '0;
          OVF[i]   <= 1'b0;
        end else if (edge_det[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            OVF[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // Read response: acknowledge every request; data holds between acknowledges.
  always_ff @(posedge CP) begin
    if (!CD) begin
      RD_ACK  <= 1'b0;
      RD_DATA <= '0;
    end else begin
      RD_ACK <= RD_REQ;
      if (RD_REQ) begin
        RD_DATA <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Bench for toggle_pulse_decoder: reads are scoreboarded through a queue, strobes counted by a monitor.
// Latency under test: PULSE 3 edges after a toggle is sampled, read data 1 edge after RD_REQ.
// Backpressure: none exercised beyond back-to-back reads.
module tb_toggle_pulse_decoder;

  logic       CP = 1'b0;
  logic       CD;
  logic [3:0] TIN;
  logic       READY;
  logic [3:0] PULSE;
  logic [3:0] OVF;
  logic       RD_REQ;
  logic [3:0] RD_CH;
  logic       RD_ACK;
  logic [7:0] RD_DATA;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_tot = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [3:0] tog_mask;
    int         reps;
    int         gap;
    logic [3:0] rd_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  toggle_pulse_decoder #(.NCH(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .CP(CP), .CD(CD), .TIN(TIN), .READY(READY), .PULSE(PULSE), .OVF(OVF),
    .RD_REQ(RD_REQ), .RD_CH(RD_CH), .RD_ACK(RD_ACK), .RD_DATA(RD_DATA)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every acknowledge must match the oldest outstanding expectation.
  always @(negedge CP) begin
    pulse_tot += $countones(PULSE);
    if (RD_ACK) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_ack", 1, 0);
      end else begin
        check("rd_data", int'(RD_DATA), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic rd(input logic [3:0] ch, input logic [7:0] e);
    RD_REQ = 1'b1;
    RD_CH  = ch;
    exp_q.push_back(e);
    tick();
    check("rd_ack", int'(RD_ACK), 1);
    RD_REQ = 1'b0;
  endtask

  task automatic toggle_mask(input logic [3:0] m, input int reps, input int gap);
    for (int r = 0; r < reps; r++) begin
      TIN = TIN ^ m;
      repeat (gap) tick();
    end
    repeat (2) tick();
  endtask

  // Releases CD and counts edges to READY, issuing one read while priming.
  task automatic wait_ready(output int edge_no);
    edge_no = 0;
    CD = 1'b1;
    for (int k = 1; k <= 10 && edge_no == 0; k++) begin
      if (k == 2) begin
        RD_REQ = 1'b1;
        RD_CH  = 4'd1;
        exp_q.push_back(8'd0);
      end
      tick();
      RD_REQ = 1'b0;
      if (READY) edge_no = k;
    end
  endtask

  initial begin
    int ready_edge;
    int first_hi;
    int hi_cnt;
    int pulse_snap;

    vecs[0]  = '{4'b0011, 3, 2, 4'd0, 8'd3};
    vecs[1]  = '{4'b0100, 4, 3, 4'd1, 8'd3};
    vecs[2]  = '{4'b1111, 2, 2, 4'd2, 8'd6};
    vecs[3]  = '{4'b0000, 0, 2, 4'd9, 8'd0};
    vecs[4]  = '{4'b0000, 0, 2, 4'd0, 8'd2};
    vecs[5]  = '{4'b0000, 0, 2, 4'd3, 8'd2};
    vecs[6]  = '{4'b1000, 1, 2, 4'd1, 8'd2};
    vecs[7]  = '{4'b0000, 0, 2, 4'd3, 8'd1};
    vecs[8]  = '{4'b0000, 0, 2, 4'd2, 8'd0};
    vecs[9]  = '{4'b0000, 0, 2, 4'd0, 8'd0};
    vecs[10] = '{4'b0000, 0, 2, 4'd1, 8'd0};

    CD = 1'b0; TIN = 4'b1010; RD_REQ = 1'b0; RD_CH = 4'd0;
    repeat (3) tick();
    check("rst_ready", int'(READY), 0);
    check("rst_pulse", int'(PULSE), 0);
    check("rst_ovf", int'(OVF), 0);
    check("rst_rd_ack", int'(RD_ACK), 0);
    check("rst_rd_data", int'(RD_DATA), 0);

    wait_ready(ready_edge);
    check("ready_edge", ready_edge, 4);
    repeat (4) tick();
    check("prime_no_pulse", pulse_tot, 0);
    rd(0, 0); rd(1, 0); rd(2, 0); rd(3, 0);

    // Single toggle on channel 2.
    TIN = TIN ^ 4'b0100;
    first_hi = 0; hi_cnt = 0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (PULSE[2]) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = j;
      end
    end
    check("single_pulse_delay", first_hi, 3);
    check("single_pulse_width", hi_cnt, 1);
    rd(2, 1);
    rd(2, 0);

    // Burst of five on channel 0, then back-to-back reads.
    toggle_mask(4'b0001, 5, 3);
    rd(0, 5);
    rd(1, 0);
    tick();
    check("rd_ack_drop", int'(RD_ACK), 0);
    check("rd_data_hold", int'(RD_DATA), 0);

    // Table of toggle patterns and reads, including an illegal channel.
    for (int v = 0; v < 11; v++) begin
      toggle_mask(vecs[v].tog_mask, vecs[v].reps, vecs[v].gap);
      rd(vecs[v].rd_ch, vecs[v].exp_data);
    end

    // Saturation at minimum legal toggle spacing.
    toggle_mask(4'b0010, 256, 2);
    check("sat_ovf_set", int'(OVF), 2);
    rd(1, 255);
    check("sat_ovf_clr", int'(OVF), 0);
    rd(1, 0);

    // Event arriving on the same edge that clears channel 3.
    toggle_mask(4'b1000, 7, 2);
    TIN = TIN ^ 4'b1000;
    tick();
    tick();
    rd(3, 7);
    check("coll_pulse", int'(PULSE[3]), 1);
    rd(3, 1);

    // Mid-run reset with live counts, nonzero RD_DATA and a pending read.
    toggle_mask(4'b0101, 3, 2);
    rd(2, 3);
    CD = 1'b0;
    RD_REQ = 1'b1;
    RD_CH = 4'd0;
    tick();
    RD_REQ = 1'b0;
    check("mrst_ready", int'(READY), 0);
    check("mrst_pulse", int'(PULSE), 0);
    check("mrst_ovf", int'(OVF), 0);
    check("mrst_rd_ack", int'(RD_ACK), 0);
    check("mrst_rd_data", int'(RD_DATA), 0);
    pulse_snap = pulse_tot;
    wait_ready(ready_edge);
    check("mrst_ready_edge", ready_edge, 4);
    repeat (3) tick();
    check("mrst_no_pulse", pulse_tot, pulse_snap);
    rd(0, 0);
    rd(2, 0);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
